// File: rtl/posit_chk_pkg.sv
// Shared types and constants for the posit stream checker.
// NaR (Not-a-Real) is the single pattern 1 followed by all zeros.
package posit_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    localparam int NAR_MAX_W = 64;

    // Callers slice the low n bits; n must be within 1..NAR_MAX_W.
    function automatic logic [NAR_MAX_W-1:0] nar_pattern(input int n);
        return {{(NAR_MAX_W-1){1'b0}}, 1'b1} << (n - 1);
    endfunction

endpackage

// File: rtl/posit_delay_line.sv
// Fixed-depth delay line: resettable valid bits alongside an unreset data pipe.
// Latency DEPTH cycles; no backpressure, one entry accepted every cycle.
module posit_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [DEPTH-1:0] vld_sr;
    logic [WIDTH-1:0] dat_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else if (clear) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // Data is only meaningful when its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        dat_sr[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            dat_sr[i] <= dat_sr[i-1];
        end
    end

    assign out_valid = vld_sr[DEPTH-1];
    assign out_data  = dat_sr[DEPTH-1];
    assign busy      = |vld_sr;

endmodule

// File: rtl/posit_stream_checker.sv
// Compares a posit unit's results against golden values delayed to line up with it,
// keeping pass/fail statistics; in_valid to cmp_valid is LATENCY+1 cycles.
module posit_stream_checker
    import posit_chk_pkg::*;
#(
    parameter int N       = 32,
    parameter int LATENCY = 4,
    parameter int TOL     = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [N-1:0]     expected,
    input  logic [N-1:0]     dut_result,
    input  logic             clear,
    output logic             cmp_valid,
    output logic             cmp_pass,
    output logic [N-1:0]     cmp_diff,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N-1:0]     max_diff,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [N-1:0]     first_err_exp,
    output logic [N-1:0]     first_err_got,
    output logic             done
);

    localparam logic [NAR_MAX_W-1:0] NAR_FULL   = nar_pattern(N);
    localparam logic [N-1:0]         NAR        = NAR_FULL[N-1:0];
    localparam logic [N-1:0]         TOL_N      = N'(TOL);
    localparam logic [6:0]           DRAIN_LAST = 7'(LATENCY);

    chk_state_t   state, state_nxt;
    logic [6:0]   drain_cnt;
    logic         cap_valid, tap_valid, line_busy, pass;
    logic [N-1:0] tap_exp, diff, cmp_exp, cmp_got;

    assign cap_valid = in_valid & start & (state == ST_RUN);

    posit_delay_line #(.WIDTH(N), .DEPTH(LATENCY)) u_exp_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (cap_valid),
        .in_data   (expected),
        .out_valid (tap_valid),
        .out_data  (tap_exp),
        .busy      (line_busy)
    );

    // NaR is not ordered against reals, so ULP tolerance never applies to it.
    always_comb begin
        diff = (tap_exp >= dut_result) ? (tap_exp - dut_result) : (dut_result - tap_exp);
        if (tap_exp == NAR || dut_result == NAR) begin
            pass = (tap_exp == dut_result);
        end else begin
            pass = (diff <= TOL_N);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = ST_RUN;
                ST_RUN:   if (!start) state_nxt = ST_DRAIN;
                ST_DRAIN: begin
                    if (start)
                        state_nxt = ST_RUN;
                    else if (drain_cnt >= DRAIN_LAST && !line_busy && !cmp_valid)
                        state_nxt = ST_DONE;
                end
                ST_DONE:  if (start) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  drain_cnt <= '0;
        else if (state != ST_DRAIN)  drain_cnt <= '0;
        else if (drain_cnt != '1)    drain_cnt <= drain_cnt + 7'd1;
    end

    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            cmp_pass  <= 1'b0;
            cmp_diff  <= '0;
            cmp_exp   <= '0;
            cmp_got   <= '0;
        end else if (clear) begin
            cmp_valid <= 1'b0;
            cmp_pass  <= 1'b0;
            cmp_diff  <= '0;
            cmp_exp   <= '0;
            cmp_got   <= '0;
        end else begin
            cmp_valid <= tap_valid;
            if (tap_valid) begin
                cmp_pass <= pass;
                cmp_diff <= diff;
                cmp_exp  <= tap_exp;
                cmp_got  <= dut_result;
            end
        end
    end

    // Statistics follow the registered compare, so a clear on either stage drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checked_cnt   <= '0;
            err_cnt       <= '0;
            max_diff      <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clear) begin
            checked_cnt   <= '0;
            err_cnt       <= '0;
            max_diff      <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (cmp_valid) begin
            if (checked_cnt != '1) checked_cnt <= checked_cnt + 1'b1;
            if (cmp_diff > max_diff) max_diff <= cmp_diff;
            if (!cmp_pass) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (!err_flag) begin
                    err_flag      <= 1'b1;
                    first_err_idx <= checked_cnt;
                    first_err_exp <= cmp_exp;
                    first_err_got <= cmp_got;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Directed bench for posit_stream_checker: two instances (TOL 0 and TOL 2) share stimulus;
// a scoreboard queue holds expected compare results until cmp_valid pops them.
module tb_posit_stream_checker;
    import posit_chk_pkg::*;

    localparam int LAT = 4;
    localparam int CW  = 8;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, clear;
    logic [31:0]   expected, dut_result;

    logic          cmp_valid_a, cmp_pass_a, err_flag_a, done_a;
    logic [31:0]   cmp_diff_a, max_diff_a, first_err_exp_a, first_err_got_a;
    logic [CW-1:0] checked_cnt_a, err_cnt_a, first_err_idx_a;
    logic          cmp_valid_b, cmp_pass_b, err_flag_b, done_b;
    logic [31:0]   cmp_diff_b, max_diff_b, first_err_exp_b, first_err_got_b;
    logic [CW-1:0] checked_cnt_b, err_cnt_b, first_err_idx_b;

    always #5 clk = ~clk;

    posit_stream_checker #(.N(32), .LATENCY(LAT), .TOL(0), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .expected(expected), .dut_result(dut_result), .clear(clear),
        .cmp_valid(cmp_valid_a), .cmp_pass(cmp_pass_a), .cmp_diff(cmp_diff_a),
        .checked_cnt(checked_cnt_a), .err_cnt(err_cnt_a), .max_diff(max_diff_a),
        .err_flag(err_flag_a), .first_err_idx(first_err_idx_a),
        .first_err_exp(first_err_exp_a), .first_err_got(first_err_got_a), .done(done_a)
    );

    posit_stream_checker #(.N(32), .LATENCY(LAT), .TOL(2), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .expected(expected), .dut_result(dut_result), .clear(clear),
        .cmp_valid(cmp_valid_b), .cmp_pass(cmp_pass_b), .cmp_diff(cmp_diff_b),
        .checked_cnt(checked_cnt_b), .err_cnt(err_cnt_b), .max_diff(max_diff_b),
        .err_flag(err_flag_b), .first_err_idx(first_err_idx_b),
        .first_err_exp(first_err_exp_b), .first_err_got(first_err_got_b), .done(done_b)
    );

    typedef struct {
        logic [31:0] diff;
        logic        pass_t0;
        logic        pass_t2;
        int          issued;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] got_pipe [LAT+1];
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    logic [31:0] e_save;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic model_pass(input logic [31:0] e, input logic [31:0] g, input int tol);
        if (e == NAR || g == NAR) return e == g;
        return absdiff(e, g) <= 32'(tol);
    endfunction

    // One clock cycle: drive a vector (and the modelled unit's result from LAT cycles ago),
    // then check any compare that became visible after the edge.
    task automatic cyc(input logic v, input logic [31:0] e, input logic [31:0] g);
        sb_t ent;
        sb_t got;
        for (int i = LAT; i > 0; i--) got_pipe[i] = got_pipe[i-1];
        got_pipe[0] = g;
        in_valid   = v;
        expected   = e;
        dut_result = got_pipe[LAT];
        if (v) begin
            ent.diff    = absdiff(e, g);
            ent.pass_t0 = model_pass(e, g, 0);
            ent.pass_t2 = model_pass(e, g, 2);
            ent.issued  = cyc_n;
            sb.push_back(ent);
        end
        @(posedge clk);
        #1;
        if (cmp_valid_a) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                got = sb.pop_front();
                chk("cmp_latency", 64'(cyc_n - got.issued), 64'(LAT));
                chk("cmp_diff", cmp_diff_a, got.diff);
                chk("cmp_pass_tol0", cmp_pass_a, got.pass_t0);
                chk("cmp_valid_tol2", cmp_valid_b, 1);
                chk("cmp_pass_tol2", cmp_pass_b, got.pass_t2);
            end
        end
        cyc_n++;
    endtask

    task automatic drain();
        start = 1'b0;
        for (int k = 0; k < 40 && !done_a; k++) cyc(1'b0, 32'd0, 32'd0);
        chk("done_after_drain", done_a, 1);
        chk("sb_empty", 64'(sb.size()), 0);
    endtask

    task automatic clr();
        start = 1'b0;
        clear = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        clear = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        expected = '0; dut_result = '0;
        for (int i = 0; i <= LAT; i++) got_pipe[i] = '0;
        #12;
        chk("rst_checked", checked_cnt_a, 0);
        chk("rst_err", err_cnt_a, 0);
        chk("rst_maxdiff", max_diff_a, 0);
        chk("rst_flag", err_flag_a, 0);
        chk("rst_cmp_valid", cmp_valid_a, 0);
        chk("rst_done", done_a, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean run of 100 vectors.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            e_save = $urandom & 32'h3fff_ffff;
            cyc(1'b1, e_save, e_save);
        end
        drain();
        chk("clean_checked", checked_cnt_a, 100);
        chk("clean_err", err_cnt_a, 0);
        chk("clean_maxdiff", max_diff_a, 0);
        chk("clean_flag", err_flag_a, 0);
        chk("clean_checked_tol2", checked_cnt_b, 100);
        clr();
        chk("clr_checked", checked_cnt_a, 0);
        chk("clr_done", done_a, 0);

        // Vector 37 off by +3.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            logic [31:0] e;
            e = $urandom & 32'h3fff_ffff;
            if (i == 37) begin
                e_save = e;
                cyc(1'b1, e, e + 32'd3);
            end else begin
                cyc(1'b1, e, e);
            end
        end
        drain();
        chk("v37_err", err_cnt_a, 1);
        chk("v37_idx", first_err_idx_a, 37);
        chk("v37_maxdiff", max_diff_a, 3);
        chk("v37_flag", err_flag_a, 1);
        chk("v37_exp", first_err_exp_a, e_save);
        chk("v37_got", first_err_got_a, e_save + 32'd3);
        chk("v37_err_tol2", err_cnt_b, 1);
        clr();

        // Tolerance boundary: diff 2 passes, diff 3 fails with TOL=2.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        cyc(1'b1, 32'd1000, 32'd1002);
        cyc(1'b1, 32'd2000, 32'd1997);
        cyc(1'b1, 32'd5000, 32'd4998);
        cyc(1'b1, 32'd7, 32'd7);
        drain();
        chk("tol_err_tol2", err_cnt_b, 1);
        chk("tol_idx_tol2", first_err_idx_b, 1);
        chk("tol_maxdiff_tol2", max_diff_b, 3);
        chk("tol_got_tol2", first_err_got_b, 32'd1997);
        chk("tol_err_tol0", err_cnt_a, 3);
        chk("tol_idx_tol0", first_err_idx_a, 0);
        clr();

        // NaR handling.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        cyc(1'b1, NAR, 32'h0000_0000);
        cyc(1'b1, NAR, NAR);
        cyc(1'b1, NAR, 32'h7fff_ffff);
        cyc(1'b1, 32'h10, 32'h11);
        drain();
        chk("nar_err_tol0", err_cnt_a, 3);
        chk("nar_err_tol2", err_cnt_b, 2);
        chk("nar_maxdiff", max_diff_a, 32'h8000_0000);
        chk("nar_maxdiff_tol2", max_diff_b, 32'h8000_0000);
        chk("nar_first_exp", first_err_exp_a, NAR);
        chk("nar_first_got", first_err_got_a, 32'h0);
        clr();

        // Clear coinciding with a failing compare at the tap.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        cyc(1'b1, 32'd100, 32'd200);
        for (int i = 0; i < LAT - 1; i++) cyc(1'b0, 32'd0, 32'd0);
        start = 1'b0;
        clear = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        clear = 1'b0;
        chk("clrcmp_err", err_cnt_a, 0);
        chk("clrcmp_flag", err_flag_a, 0);
        chk("clrcmp_valid", cmp_valid_a, 0);
        chk("clrcmp_state", 64'(u_a.state), 64'(ST_IDLE));
        sb.delete();
        cyc(1'b0, 32'd0, 32'd0);
        chk("clrcmp_err_later", err_cnt_a, 0);
        chk("clrcmp_checked_later", checked_cnt_a, 0);

        // Restart from DRAIN keeps in-flight compares.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i + 50), 32'(i + 50));
        start = 1'b0;
        cyc(1'b0, 32'd0, 32'd0);
        chk("redrain_state", 64'(u_a.state), 64'(ST_DRAIN));
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'(i + 90), 32'(i + 90));
        drain();
        chk("redrain_checked", checked_cnt_a, 5);
        clr();

        // Asynchronous reset mid-run, then counter saturation.
        start = 1'b1;
        cyc(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i * 100), 32'(i * 100 + 5));
        chk("pre_rst_err", err_cnt_a, 3);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_checked", checked_cnt_a, 0);
        chk("arst_err", err_cnt_a, 0);
        chk("arst_maxdiff", max_diff_a, 0);
        chk("arst_flag", err_flag_a, 0);
        chk("arst_cmp_valid", cmp_valid_a, 0);
        chk("arst_first_got", first_err_got_a, 0);
        chk("arst_state", 64'(u_a.state), 64'(ST_IDLE));
        #2 rst_n = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 265; i++) begin
            logic [31:0] e;
            e = $urandom & 32'h3fff_ffff;
            cyc(1'b1, e, e + 32'd1);
        end
        drain();
        chk("sat_err", err_cnt_a, 8'hff);
        chk("sat_checked", checked_cnt_a, 8'hff);
        chk("sat_flag", err_flag_a, 1);
        chk("sat_idx", first_err_idx_a, 0);
        chk("sat_maxdiff", max_diff_a, 1);
        chk("sat_err_tol2", err_cnt_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
